// File: rtl/usbsd_rvld_seq.sv
// rtl/usbsd_rvld_seq.sv - RVLD strobe sequencer with rack handshake and Avalon-MM registers
// Optional ack timeout (TIMEOUT register, counter, status bit) built when USBSD_RVLD_SEQ_TIMEOUT_EN is defined.
module usbsd_rvld_seq #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rvld,
    input  logic        rack,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_ACK,
        S_GAP
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_remaining;
    logic [7:0]             r_width;
    logic [7:0]             r_gap;
    logic [15:0]            r_cnt;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_aborted;
    logic                   r_irq_en;
    logic                   r_rvld;
    logic                   r_irq;
    logic [SYNC_STAGES-1:0] r_rack_sync;
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
    logic [15:0]            r_tmo_val;
`endif

    logic                   w_wr;
    logic                   w_wr_ctrl;
    logic                   w_start;
    logic                   w_abort;
    logic                   w_busy;
    logic                   w_rack_s;
    logic [7:0]             w_width_eff;
    logic [15:0]            w_cnt_inc;
    logic [2*CNT_W-1:0]     w_cnt_cat;
    logic                   w_unused_bits;

    assign w_wr          = chipselect & ~write_n;
    assign w_wr_ctrl     = w_wr && (address == 2'd0);
    assign w_start       = w_wr_ctrl & writedata[0];
    assign w_abort       = w_wr_ctrl & writedata[2];
    assign w_busy        = (r_state != S_IDLE);
    assign w_rack_s      = r_rack_sync[SYNC_STAGES-1];
    assign w_width_eff   = (r_width == 8'd0) ? 8'd1 : r_width;
    // One shared phase counter; saturating so a stuck rack in GAP never wraps the gap test.
    assign w_cnt_inc     = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_cnt_cat     = {r_remaining, r_count};
    assign w_unused_bits = &{1'b0, writedata[31:16]};

    assign rvld = r_rvld;
    assign irq  = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rack_sync <= '0;
        end else begin
            r_rack_sync <= {r_rack_sync[SYNC_STAGES-2:0], rack};
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {27'd0, r_aborted, r_irq_en, r_timeout, r_done, w_busy};
            2'd1: readdata = 32'(w_cnt_cat);
            2'd2: readdata = {16'd0, r_gap, r_width};
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
            2'd3: readdata = {16'd0, r_tmo_val};
`endif
            default: readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_remaining <= '0;
            r_width     <= 8'd1;
            r_gap       <= 8'd0;
            r_cnt       <= 16'd0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_irq_en    <= 1'b0;
            r_rvld      <= 1'b0;
            r_irq       <= 1'b0;
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
            r_tmo_val   <= 16'd0;
`endif
        end else begin
            r_irq <= r_done & r_irq_en;

            if (w_wr && !w_busy) begin
                case (address)
                    2'd1: r_count <= writedata[CNT_W-1:0];
                    2'd2: begin
                        r_width <= writedata[7:0];
                        r_gap   <= writedata[15:8];
                    end
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
                    2'd3: r_tmo_val <= writedata[15:0];
`endif
                    default: ;
                endcase
            end

            // W1C clears come first so a same-cycle hardware set wins.
            if (w_wr_ctrl) begin
                r_irq_en <= writedata[3];
                if (writedata[1]) r_done    <= 1'b0;
                if (writedata[4]) r_timeout <= 1'b0;
            end

            if (w_abort) begin
                r_state   <= S_IDLE;
                r_rvld    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            if (r_count != '0) begin
                                r_remaining <= r_count;
                                r_done      <= 1'b0;
                                r_timeout   <= 1'b0;
                                r_aborted   <= 1'b0;
                                r_cnt       <= 16'd0;
                                r_rvld      <= 1'b1;
                                r_state     <= S_ASSERT;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_ASSERT: begin
                        if (w_cnt_inc == {8'd0, w_width_eff}) begin
                            r_rvld  <= 1'b0;
                            r_cnt   <= 16'd0;
                            r_state <= S_WAIT_ACK;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (w_rack_s) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                            r_cnt       <= 16'd0;
                            r_state     <= S_GAP;
                        end else begin
                            r_cnt <= w_cnt_inc;
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
                            if ((r_tmo_val != 16'd0) && (w_cnt_inc == r_tmo_val)) begin
                                r_timeout <= 1'b1;
                                r_state   <= S_IDLE;
                            end
`endif
                        end
                    end
                    S_GAP: begin
                        if ((w_cnt_inc >= {8'd0, r_gap}) && !w_rack_s) begin
                            if (r_remaining == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt   <= 16'd0;
                                r_rvld  <= 1'b1;
                                r_state <= S_ASSERT;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usbsd_rvld_seq.sv
// tb/tb_usbsd_rvld_seq.sv - self-checking bench for usbsd_rvld_seq with a per-cycle reference model
module tb_usbsd_rvld_seq;

    localparam int SYNC = 2;
`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_HIGH = 1, PH_WAIT = 2, PH_GAP = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        rvld;
    logic        rack;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    usbsd_rvld_seq #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .rvld(rvld), .rack(rack), .irq(irq)
    );

    always #5 clk = ~clk;

    // Device: rack echoes rvld dev_dly cycles later, or stays low in mode 1.
    int          dev_mode = 0;
    int          dev_dly  = 5;
    logic [31:0] rv_hist  = '0;
    initial forever begin @(negedge clk); rv_hist = {rv_hist[30:0], rvld}; end
    initial forever begin
        @(posedge clk); #2;
        rack = (dev_mode == 0) ? rv_hist[dev_dly-1] : 1'b0;
    end

    // Reference model: phase plus elapsed cycles in that phase.
    int          m_ph, m_t;
    logic [15:0] m_cnt, m_rem, m_tv;
    logic [7:0]  m_wid, m_gap;
    bit          m_done, m_tmo, m_abt, m_ien, m_irq;
    bit          rq[$];

    task automatic mreset();
        m_ph = PH_IDLE; m_t = 0; m_cnt = 0; m_rem = 0; m_tv = 0;
        m_wid = 8'd1; m_gap = 0; m_done = 0; m_tmo = 0; m_abt = 0; m_ien = 0; m_irq = 0;
        rq.delete();
        for (int i = 0; i < SYNC; i++) rq.push_back(1'b0);
    endtask

    task automatic mstep();
        bit wr, wc, st, ab, syn;
        logic [1:0]  a;
        logic [31:0] d;
        a = address; d = writedata;
        wr = chipselect && !write_n;
        wc = wr && (a == 2'd0);
        st = wc && d[0];
        ab = wc && d[2];
        syn = rq[0];
        void'(rq.pop_front());
        rq.push_back(rack);
        m_irq = m_done && m_ien;
        if (wr && m_ph == PH_IDLE) begin
            if (a == 2'd1) m_cnt = d[15:0];
            if (a == 2'd2) begin m_wid = d[7:0]; m_gap = d[15:8]; end
            if (a == 2'd3 && TMO_EN) m_tv = d[15:0];
        end
        if (wc) begin
            m_ien = d[3];
            if (d[1]) m_done = 0;
            if (d[4]) m_tmo = 0;
        end
        if (ab) begin
            m_abt = 1; m_ph = PH_IDLE;
        end else if (m_ph == PH_IDLE) begin
            if (st && m_cnt != 0) begin
                m_rem = m_cnt; m_done = 0; m_tmo = 0; m_abt = 0; m_ph = PH_HIGH; m_t = 0;
            end else if (st) m_done = 1;
        end else if (m_ph == PH_HIGH) begin
            m_t++;
            if (m_t == ((m_wid == 0) ? 1 : int'(m_wid))) begin m_ph = PH_WAIT; m_t = 0; end
        end else if (m_ph == PH_WAIT) begin
            if (syn) begin m_rem = m_rem - 16'd1; m_ph = PH_GAP; m_t = 0; end
            else begin
                m_t++;
                if (TMO_EN && m_tv != 0 && m_t == int'(m_tv)) begin m_tmo = 1; m_ph = PH_IDLE; end
            end
        end else begin
            m_t++;
            if (m_t >= int'(m_gap) && !syn) begin
                if (m_rem == 0) begin m_done = 1; m_ph = PH_IDLE; end
                else begin m_ph = PH_HIGH; m_t = 0; end
            end
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0: return {27'd0, m_abt, m_ien, m_tmo, m_done, m_ph != PH_IDLE};
            2'd1: return {m_rem, m_cnt};
            2'd2: return {16'd0, m_gap, m_wid};
            default: return TMO_EN ? {16'd0, m_tv} : 32'd0;
        endcase
    endfunction

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) mreset(); else mstep();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("rvld", {31'd0, rvld}, {31'd0, m_ph == PH_HIGH});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("readdata", readdata, m_rd(address));
        end
    end

    // Pulse monitor, independent of the model.
    int pulses = 0, badlen = 0, curlen = 0, exp_w = 0;
    logic prev_rvld = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rvld && !prev_rvld) begin pulses++; curlen = 1; end
        else if (rvld) curlen++;
        else if (prev_rvld && exp_w != 0 && curlen != exp_w) badlen++;
        prev_rvld = rvld;
    end

    task automatic clr_mon(input int w);
        pulses = 0; badlen = 0; exp_w = w;
    endtask

    task automatic tick();
        @(posedge clk); #2;
        if (!chipselect) address = 2'($urandom_range(0, 3));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'($urandom);
        address = 2'($urandom_range(0, 3));
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; #1; d = readdata;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (m_ph != PH_IDLE && n < budget) begin tick(); n++; end
        chk(nm, {31'd0, m_ph == PH_IDLE}, 32'd1);
    endtask

    logic [31:0] v;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'd0; rack = 1'b0;
        repeat (3) @(posedge clk);
        #2; reset_n = 1'b1; chk_en = 1'b1;
        rd(2'd0, v); chk("reset status", v, 32'h0);
        rd(2'd2, v); chk("reset timing", v, 32'h1);
        chk("reset rvld", {31'd0, rvld}, 32'd0);

        // Basic: 3 pulses of width 4, gap 2, rack echoed 5 cycles later
        dev_mode = 0; dev_dly = 5;
        wr(2'd1, 32'd3); wr(2'd2, 32'h0204); clr_mon(4);
        wr(2'd0, 32'h9);
        chk("rvld after start", {31'd0, rvld}, 32'd1);
        wait_idle(500, "basic idle");
        chk("basic pulses", pulses, 32'd3);
        chk("basic widths", badlen, 32'd0);
        rd(2'd0, v); chk("basic status", v, 32'h0A);
        rd(2'd1, v); chk("basic count", v, 32'h00000003);
        tick();
        chk("basic irq", {31'd0, irq}, 32'd1);

        // Busy protection and W1C done
        dev_dly = 3;
        wr(2'd1, 32'd4); wr(2'd2, 32'h0102); clr_mon(2);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        wr(2'd0, 32'h9);
        wait_idle(500, "busy idle");
        chk("busy pulses", pulses, 32'd4);
        tick();
        chk("irq before w1c", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0A);
        rd(2'd0, v); chk("w1c status", v, 32'h08);
        tick();
        chk("irq after w1c", {31'd0, irq}, 32'd0);

        // Zero count
        wr(2'd1, 32'd0); clr_mon(0);
        wr(2'd0, 32'h1);
        rd(2'd0, v); chk("zero status", v, 32'h02);
        repeat (5) tick();
        chk("zero pulses", pulses, 32'd0);

        // Abort after two acks, during the third pulse
        dev_dly = 4;
        wr(2'd1, 32'd5); wr(2'd2, 32'h0205); clr_mon(0);
        wr(2'd0, 32'h1);
        for (int n = 0; n < 400 && !(m_rem == 16'd3 && m_ph == PH_HIGH); n++) tick();
        chk("abort reached", {31'd0, m_rem == 16'd3 && m_ph == PH_HIGH}, 32'd1);
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h4);
        chk("abort rvld", {31'd0, rvld}, 32'd0);
        rd(2'd0, v); chk("abort status", v, 32'h10);
        rd(2'd1, v); chk("abort count", v, 32'h00030005);

`ifdef USBSD_RVLD_SEQ_TIMEOUT_EN
        dev_mode = 1;
        wr(2'd3, 32'd10); wr(2'd1, 32'd4); wr(2'd2, 32'h0003); clr_mon(3);
        wr(2'd0, 32'h1);
        wait_idle(200, "timeout idle");
        rd(2'd0, v); chk("timeout status", v, 32'h04);
        rd(2'd1, v); chk("timeout count", v, 32'h00040004);
        chk("timeout pulses", pulses, 32'd1);
        chk("timeout widths", badlen, 32'd0);
        dev_mode = 0;
`endif

        // Randomized sequences checked by the model
        for (int it = 0; it < 30; it++) begin
            int tv;
            tv = $urandom_range(0, 20);
            dev_dly = $urandom_range(1, 8);
            dev_mode = (TMO_EN && tv != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            wr(2'd1, 32'($urandom_range(1, 6)));
            wr(2'd2, {16'd0, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 5))});
            wr(2'd3, 32'(tv));
            clr_mon(0);
            wr(2'd0, 32'($urandom_range(0, 1) << 3) | 32'h1);
            if ($urandom_range(0, 1) == 0) wr(2'd1, 32'($urandom_range(0, 9)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 40)) tick();
                wr(2'd0, 32'h4 | 32'($urandom_range(0, 1) << 3));
            end
            wait_idle(3000, "random idle");
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 1) == 0) wr(2'd0, 32'h12 | 32'($urandom_range(0, 1) << 3));
        end
        dev_mode = 0;

        // Reset mid-ASSERT
        wr(2'd1, 32'd2); wr(2'd2, 32'd6);
        wr(2'd0, 32'h9);
        tick(); tick();
        reset_n = 1'b0; #1;
        chk("mid reset rvld", {31'd0, rvld}, 32'd0);
        chk("mid reset irq", {31'd0, irq}, 32'd0);
        rd(2'd0, v); chk("mid reset status", v, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        rd(2'd2, v); chk("post reset timing", v, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
